// File: rtl/cskip_a32_pkg.sv
// Shared constants for the 32-bit carry-skip adder cskip_a32.
// Holds the datapath widths, the default skip-block width and the derived
// block count used by the top level and the testbench.
package cskip_a32_pkg;

  localparam int DATA_W          = 32;
  localparam int SUM_W           = 33;
  localparam int BLOCK_W_DEFAULT = 4;

  // Number of skip blocks needed to cover the datapath for a block width.
  function automatic int num_blocks(input int bw);
    return DATA_W / bw;
  endfunction

  localparam int NUM_BLOCKS = num_blocks(BLOCK_W_DEFAULT);

endpackage : cskip_a32_pkg

// File: rtl/cskip_a32_block.sv
// cskip_block: one W-bit ripple-carry block with a carry-skip mux.
// When every bit position propagates, the incoming carry bypasses the
// ripple chain and drives cout directly.
module cskip_block
  import cskip_a32_pkg::*;
#(
  parameter int W = BLOCK_W_DEFAULT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic c_ripple;
  logic p_grp;

  // Ripple the carry through the block and build the group propagate term.
  always_comb begin
    c_ripple = cin;
    p_grp    = 1'b1;
    s        = '0;
    for (int i = 0; i < W; i++) begin
      s[i]     = a[i] ^ b[i] ^ c_ripple;
      c_ripple = (a[i] & b[i]) | (c_ripple & (a[i] ^ b[i]));
      p_grp    = p_grp & (a[i] ^ b[i]);
    end
  end

  // Skip mux: a fully propagating block forwards its carry-in unchanged.
  assign cout = p_grp ? cin : c_ripple;

endmodule : cskip_block

// File: rtl/cskip_a32.sv
// cskip_a32: registered 32-bit signed carry-skip adder producing a 33-bit
// exact sum, one result per cycle.
// Optional build macro: CSKIP_A32_IN_REG_EN registers A, B and in_valid in
// front of the adder (latency 2 instead of 1). BLOCK_W must divide 32
// (2, 4 or 8).
module cskip_a32
  import cskip_a32_pkg::*;
#(
  parameter int BLOCK_W = BLOCK_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] A,
  input  logic signed [DATA_W-1:0] B,
  output logic                     out_valid,
  output logic signed [SUM_W-1:0]  SUM
);

  localparam int NBLK = num_blocks(BLOCK_W);

  logic [DATA_W-1:0] add_a;
  logic [DATA_W-1:0] add_b;
  logic              add_vld;
  logic [DATA_W-1:0] sum_lo;
  logic              c32;
  logic [SUM_W-1:0]  sum_d;
  logic [SUM_W-1:0]  sum_q;
  logic              out_valid_q;

`ifdef CSKIP_A32_IN_REG_EN
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              vld_q;

  // Input stage: capture the operand pair; reset clears it so nothing stale
  // reaches the adder after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      a_q   <= A;
      b_q   <= B;
      vld_q <= in_valid;
    end
  end

  assign add_a   = a_q;
  assign add_b   = b_q;
  assign add_vld = vld_q;
`else
  assign add_a   = A;
  assign add_b   = B;
  assign add_vld = in_valid;
`endif

  // Chain of skip blocks; block 0 has no carry-in, each later block takes
  // the carry-out of its predecessor.
  for (genvar gi = 0; gi < NBLK; gi++) begin : gen_blk
    logic blk_cin;
    logic blk_cout;

    if (gi == 0) begin : gen_first
      assign blk_cin = 1'b0;
    end else begin : gen_rest
      assign blk_cin = gen_blk[gi-1].blk_cout;
    end

    cskip_block #(
      .W(BLOCK_W)
    ) u_blk (
      .a   (add_a[gi*BLOCK_W +: BLOCK_W]),
      .b   (add_b[gi*BLOCK_W +: BLOCK_W]),
      .cin (blk_cin),
      .s   (sum_lo[gi*BLOCK_W +: BLOCK_W]),
      .cout(blk_cout)
    );
  end

  assign c32 = gen_blk[NBLK-1].blk_cout;

  // The 33rd bit is the true sign of the sign-extended sum, so no overflow
  // is possible.
  assign sum_d = {add_a[DATA_W-1] ^ add_b[DATA_W-1] ^ c32, sum_lo};

  // Output register: load on a valid pair, otherwise hold the last result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= add_vld;
      if (add_vld) begin
        sum_q <= sum_d;
      end
    end
  end

  assign SUM       = sum_q;
  assign out_valid = out_valid_q;

endmodule : cskip_a32

// File: tb/tb_cskip_a32.sv
// Self-checking bench for cskip_a32: directed boundary cases, a 1000-pair
// back-to-back random stream with a mid-stream reset, and a gappy random
// phase, all checked against a behavioural model of the adder.
module tb_cskip_a32;

  import cskip_a32_pkg::*;

`ifdef CSKIP_A32_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int HIST_N = 8192;

  logic                     clk;
  logic                     rst_n;
  logic                     in_valid;
  logic signed [DATA_W-1:0] A;
  logic signed [DATA_W-1:0] B;
  logic                     out_valid;
  logic signed [SUM_W-1:0]  SUM;

  cskip_a32 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .SUM      (SUM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Per-edge record of what was driven: reset level, valid, exact sum.
  bit             hist_r [HIST_N];
  bit             hist_v [HIST_N];
  logic [SUM_W-1:0] hist_s [HIST_N];

  logic             exp_v;
  logic [SUM_W-1:0] exp_s;

  task automatic check_eq(input string tag, input logic [SUM_W-1:0] got,
                          input logic [SUM_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Exact signed sum using wide integer arithmetic.
  function automatic logic [SUM_W-1:0] ref_sum(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    return s[SUM_W-1:0];
  endfunction

  // Drive one clock cycle, update the model, then check outputs.
  task automatic cycle(input bit r, input bit v, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] b);
    int  src;
    bit  clean;
    rst_n    = r;
    in_valid = v;
    A        = a;
    B        = b;
    @(posedge clk);
    hist_r[cyc] = r;
    hist_v[cyc] = v;
    hist_s[cyc] = ref_sum(a, b);
    // A result appears LAT edges after its pair was sampled, provided no
    // reset hit any edge from sampling through the output edge.
    src   = cyc - LAT + 1;
    clean = (src >= 0);
    for (int k = (src < 0 ? 0 : src); k <= cyc; k++)
      if (!hist_r[k]) clean = 1'b0;
    if (!r) begin
      exp_v = 1'b0;
      exp_s = '0;
    end else if (clean && hist_v[src]) begin
      exp_v = 1'b1;
      exp_s = hist_s[src];
    end else begin
      exp_v = 1'b0;
    end
    #1;
    check_eq("out_valid", {32'd0, out_valid}, {32'd0, exp_v});
    check_eq("sum", SUM, exp_s);
    if (exp_v)
      $display("txn cyc=%0d A=%h B=%h SUM=%h", cyc, hist_s[src] === SUM ? a : a, b, SUM);
    cyc++;
  endtask

  // Issue one pair, let it reach the output, and check against a fixed value.
  task automatic directed(input string tag, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] b, input logic [SUM_W-1:0] want);
    cycle(1'b1, 1'b1, a, b);
    for (int i = 1; i < LAT; i++) cycle(1'b1, 1'b0, '0, '0);
    check_eq(tag, SUM, want);
  endtask

  function automatic logic [DATA_W-1:0] rand_op(input logic [DATA_W-1:0] other);
    int sel;
    sel = $urandom_range(0, 7);
    case (sel)
      0:       return ~other;            // full propagate chain
      1:       return (~other) + 32'd1;  // negation
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [DATA_W-1:0] ra;
    logic [DATA_W-1:0] rb;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;

    // Reset with a valid pair present: it must be discarded.
    cycle(1'b0, 1'b1, 32'd123, 32'd456);
    cycle(1'b0, 1'b1, 32'd7, 32'd9);
    check_eq("reset_sum", SUM, 33'd0);
    cycle(1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, '0, '0);

    directed("add_10_15",  32'd10,        32'd15,        33'd25);
    directed("min_min",    32'h8000_0000, 32'h8000_0000, 33'h1_0000_0000);
    directed("max_max",    32'h7FFF_FFFF, 32'h7FFF_FFFF, 33'h0_FFFF_FFFE);
    directed("cancel_10",  32'd10,        -32'sd10,      33'd0);
    directed("cancel_aa",  32'hAAAA_AAAA, 32'h5555_5555, 33'h1_FFFF_FFFF);
    directed("zero_m1",    32'd0,         32'hFFFF_FFFF, 33'h1_FFFF_FFFF);
    directed("skip_m1_p1", 32'hFFFF_FFFF, 32'd1,         33'd0);
    directed("skip_max_1", 32'h7FFF_FFFF, 32'd1,         33'h0_8000_0000);

    // Back-to-back random stream with a reset pulse in the middle.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = rand_op(ra);
      if (i == 500 || i == 501) cycle(1'b0, 1'b1, ra, rb);
      else                      cycle(1'b1, 1'b1, ra, rb);
      if (i == 500) check_eq("midreset_sum", SUM, 33'd0);
    end

    // Random valid gaps: SUM must hold across idle cycles.
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = rand_op(ra);
      cycle(1'b1, bit'($urandom_range(0, 1)), ra, rb);
    end
    for (int i = 0; i < LAT + 1; i++) cycle(1'b1, 1'b0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_cskip_a32

// File: doc/cskip_a32.md
CSKIP_A32 -- requirements
Module: cskip_a32

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-low reset; the clock port is clk, the reset port is rst_n.
REQ-002 Parameter BLOCK_W, default 4: skip-block width in bits; legal values are 2, 4 and 8 (each divides 32).
REQ-003 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 Port rst_n, input, 1 bit: synchronous active-low reset, sampled on the clk rising edge.
REQ-005 Port in_valid, input, 1 bit: A and B carry an operand pair this cycle.
REQ-006 Port A, input, 32 bits, signed two's complement: addend.
REQ-007 Port B, input, 32 bits, signed two's complement: addend.
REQ-008 Port out_valid, output, 1 bit: SUM holds a new result this cycle.
REQ-009 Port SUM, output, 33 bits, signed two's complement: registered full-precision sum.

Function
REQ-010 SUM SHALL equal sign_extend33(A) + sign_extend33(B), exact, with no overflow or saturation possible.
REQ-011 SUM[32] SHALL be A[31] ^ B[31] ^ c32, where c32 is the carry out of bit 31.
REQ-012 The 32-bit datapath SHALL be split into 32/BLOCK_W ripple blocks; carry-in to bit 0 is 0.
REQ-013 Each block SHALL form a group propagate P = AND of (A[i]^B[i]) over its bits; block carry-out = P ? block carry-in : internal ripple carry-out.
REQ-014 Latency SHALL be 1 cycle: a pair sampled with in_valid=1 at edge N appears on SUM, with out_valid=1, after edge N.
REQ-015 Every cycle SHALL accept a new operand pair (throughput 1/cycle), with no backpressure.
REQ-016 When in_valid=0, out_valid SHALL be 0 on the next cycle and SUM SHALL hold its previous value.
REQ-017 A back-to-back sequence of valid pairs SHALL produce back-to-back results in order.

Reset
REQ-018 While rst_n=0 at a clk edge, SUM SHALL become 33'd0 and out_valid SHALL become 0.
REQ-019 An operand pair sampled in the same cycle that reset is asserted SHALL be discarded.
REQ-020 In-flight pipeline contents SHALL be discarded when reset is asserted mid-operation.
REQ-021 The first valid pair after rst_n returns high SHALL be processed normally.

Configuration
REQ-022 Macro CSKIP_A32_IN_REG_EN: when defined, A, B and in_valid SHALL be registered before the adder, making latency 2 cycles.
REQ-023 When CSKIP_A32_IN_REG_EN is defined, the input registers SHALL reset to 0.
REQ-024 When CSKIP_A32_IN_REG_EN is undefined, latency SHALL be 1 cycle as in REQ-014.
REQ-025 The function of REQ-010 SHALL be identical with and without CSKIP_A32_IN_REG_EN.

Structure
REQ-026 Package cskip_a32_pkg SHALL hold constants DATA_W=32, SUM_W=33, the default BLOCK_W, and the derived NUM_BLOCKS.
REQ-027 One sub-module, cskip_block, SHALL implement one BLOCK_W-bit ripple block with skip mux: inputs a, b, cin; outputs s, cout.
REQ-028 cskip_a32 SHALL generate-instantiate NUM_BLOCKS copies of cskip_block plus the output registers and the sign-bit logic.

Verification
REQ-029 A=10, B=15, in_valid=1 -> one cycle later SUM=25, out_valid=1.
REQ-030 Boundary operands:
- A=B=-2147483648 -> SUM=-4294967296 (33'h1_0000_0000).
- A=B=2147483647 -> SUM=4294967294 (33'h0_FFFF_FFFE).
REQ-031 Sign cancellation:
- A=10, B=-10 -> SUM=0.
- A=-1431655766, B=1431655765 -> SUM=-1 (33'h1_FFFF_FFFF).
- A=0, B=-1 -> SUM=-1.
REQ-032 Full skip chain: A=32'hFFFF_FFFF, B=1 -> SUM=0.
REQ-033 Full skip chain: A=32'h7FFF_FFFF, B=1 -> SUM=2147483648.
REQ-034 Streaming and reset: a random back-to-back stream of 1000 pairs matches the reference A+B at the stated latency; asserting rst_n=0 mid-stream gives SUM=0 and out_valid=0 on the next cycle, with no stale result afterwards.
